mod_product_param: RTL and testbench



---
 rtl/mod_product_param.sv | 166 ++++++++++++++++
 tb/tb_mod_product_param.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_product_param.sv
// -----------------------------------------------------------------------------
// mod_product_param
//
// Bit-serial modular multiplier. Computes either (a * b) mod N (mode 0) or
// (b * 2^k) mod N (mode 1, Montgomery pre-scale term), doing one Horner step
// per clock over the low k bits of a, MSB first.
//
// Parameters
//   W   operand / modulus width in bits
//   KW  width of the bit-count input
//
// Ports
//   i_clk     clock, rising edge
//   i_rst_n   asynchronous active-low reset
//   i_valid   start request, accepted when the block is free
//   i_abort   synchronous abort of a running operation (wins over i_valid)
//   i_mode    0: (a*b) mod N, 1: (b*2^k) mod N
//   i_N       modulus (N = 0 yields result 0)
//   i_a       multiplier, low k bits used MSB first
//   i_b       multiplicand, must be < N
//   i_k       bit count, clamped to W
//   o_result  result, held until the next completed operation
//   o_ready   one-cycle pulse marking o_result valid
//   o_busy    high while an operation is in flight (CALC and DONE)
// -----------------------------------------------------------------------------
module mod_product_param #(
    parameter int W  = 256,
    parameter int KW = $clog2(W) + 1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_valid,
    input  logic          i_abort,
    input  logic          i_mode,
    input  logic [W-1:0]  i_N,
    input  logic [W-1:0]  i_a,
    input  logic [W-1:0]  i_b,
    input  logic [KW-1:0] i_k,
    output logic [W-1:0]  o_result,
    output logic          o_ready,
    output logic          o_busy
);

    localparam int IW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_e;

    state_e        state_q;
    logic [W-1:0]  n_q, a_q, b_q, r_q, result_q;
    logic          mode_q;
    logic [KW-1:0] cnt_q;
    logic          ready_q, busy_q;

    // Capture-side values
    logic [KW-1:0] k_clamp;
    logic [W-1:0]  r_init;
    logic          accept;

    assign k_clamp = (i_k > KW'(W)) ? KW'(W) : i_k;
    // N = 0 forces the running value to zero so the result comes out as 0.
    assign r_init  = (i_N == '0) ? '0 : (i_mode ? i_b : '0);

    // DONE's exit edge doubles as the IDLE sampling point, so a held i_valid
    // restarts immediately and operations issue every k'+1 cycles.
    assign accept  = i_valid && !i_abort && (state_q == S_IDLE || state_q == S_DONE);

    // One Horner step: r <- (2r + bit*b) mod N, using W+1-bit intermediates.
    logic [KW-1:0] idx;
    logic          bit_in;
    logic [W:0]    dbl, acc;
    logic [W-1:0]  r_step;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // otherwise a path that skips an assignment infers a latch.
        idx    = cnt_q - KW'(1);
        bit_in = !mode_q && a_q[idx[IW-1:0]];
        dbl    = {r_q, 1'b0};
        if (n_q != '0 && dbl >= {1'b0, n_q}) begin
            dbl = dbl - {1'b0, n_q};
        end
        acc = dbl + (bit_in ? {1'b0, b_q} : '0);
        if (n_q != '0 && acc >= {1'b0, n_q}) begin
            acc = acc - {1'b0, n_q};
        end
        // With r < N and b < N the reduced value always fits in W bits.
        r_step = (n_q == '0) ? '0 : acc[W-1:0];
    end

    // The MSB of acc is always 0 after reduction; idx's top bit only feeds the
    // compare-free index slice.
    logic unused_bits;
    assign unused_bits = ^{acc[W], idx};

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= S_IDLE;
            n_q      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            r_q      <= '0;
            mode_q   <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            if (accept) begin
                n_q    <= i_N;
                a_q    <= i_a;
                b_q    <= i_b;
                mode_q <= i_mode;
                r_q    <= r_init;
                cnt_q  <= k_clamp;
                busy_q <= 1'b1;
                if (k_clamp == '0) begin
                    state_q  <= S_DONE;
                    result_q <= r_init;
                    ready_q  <= 1'b1;
                end else begin
                    state_q <= S_CALC;
                end
            end else begin
                case (state_q)
                    S_IDLE: begin
                        busy_q <= 1'b0;
                    end
                    S_CALC: begin
                        if (i_abort) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            r_q   <= r_step;
                            cnt_q <= cnt_q - KW'(1);
                            if (cnt_q == KW'(1)) begin
                                state_q  <= S_DONE;
                                result_q <= r_step;
                                ready_q  <= 1'b1;
                            end
                        end
                    end
                    S_DONE: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_result = result_q;
    assign o_ready  = ready_q;
    assign o_busy   = busy_q;

endmodule

// File: tb/tb_mod_product_param.sv
// -----------------------------------------------------------------------------
// tb_mod_product_param
//
// Drives a W=256 and a W=16 instance of mod_product_param. Expected results
// and o_ready cycles are pushed into per-instance queues at start time; a
// monitor pops and compares whenever o_ready is seen.
// -----------------------------------------------------------------------------
module tb_mod_product_param;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // 256-bit instance
    logic         v0 = 0, ab0 = 0, md0 = 0;
    logic [255:0] n0 = '0, a0 = '0, b0 = '0;
    logic [8:0]   k0 = '0;
    logic [255:0] res0;
    logic         rdy0, busy0;

    // 16-bit instance
    logic         v1 = 0, ab1 = 0, md1 = 0;
    logic [15:0]  n1 = '0, a1 = '0, b1 = '0;
    logic [4:0]   k1 = '0;
    logic [15:0]  res1;
    logic         rdy1, busy1;

    mod_product_param #(.W(256)) dut256 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(v0), .i_abort(ab0), .i_mode(md0),
        .i_N(n0), .i_a(a0), .i_b(b0), .i_k(k0),
        .o_result(res0), .o_ready(rdy0), .o_busy(busy0)
    );

    mod_product_param #(.W(16)) dut16 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(v1), .i_abort(ab1), .i_mode(md1),
        .i_N(n1), .i_a(a1), .i_b(b1), .i_k(k1),
        .o_result(res1), .o_ready(rdy1), .o_busy(busy1)
    );

    typedef struct {
        logic [255:0] res;
        int           cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;
    int last_cap = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain wide arithmetic on the mathematical definition.
    function automatic logic [255:0] model(input bit mode, input logic [255:0] n,
                                           input logic [255:0] a, input logic [255:0] b,
                                           input int k);
        logic [767:0] p;
        logic [767:0] rem;
        logic [255:0] mask;
        if (n == '0) return '0;
        mask = (k >= 256) ? {256{1'b1}} : ((256'd1 << k) - 256'd1);
        if (mode) p = 768'(b) << k;
        else      p = 768'(a & mask) * 768'(b);
        rem = p % 768'(n);
        return rem[255:0];
    endfunction

    function automatic logic [255:0] rand_bits(input int bits);
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        if (bits < 256) v = v & ((256'd1 << bits) - 256'd1);
        return v;
    endfunction

    // Monitors: every o_ready must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rdy0) begin
            if (q0.size() == 0) begin
                check("dut256_unexpected_ready", 256'(rdy0), 256'd0);
            end else begin
                e0 = q0.pop_front();
                check("dut256_result", res0, e0.res);
                check("dut256_ready_cycle", 256'(cyc), 256'(e0.cyc));
            end
        end
        if (rdy1) begin
            if (q1.size() == 0) begin
                check("dut16_unexpected_ready", 256'(rdy1), 256'd0);
            end else begin
                e1 = q1.pop_front();
                check("dut16_result", 256'(res1), e1.res);
                check("dut16_ready_cycle", 256'(cyc), 256'(e1.cyc));
            end
        end
    end

    task automatic wait_idle(input bit sel);
        for (int i = 0; i < 600; i++) begin
            if (!(sel ? busy1 : busy0)) return;
            @(posedge clk); #1;
        end
        check("idle_timeout", 256'(sel ? busy1 : busy0), 256'd0);
    endtask

    // Issues a one-cycle start; returns 1ns after the capture edge.
    task automatic start_op(input bit sel, input bit mode, input logic [255:0] n,
                            input logic [255:0] a, input logic [255:0] b,
                            input int k, output int kc);
        int   w;
        exp_t e;
        w = sel ? 16 : 256;
        if (sel) begin
            n = n & 256'hFFFF;
            a = a & 256'hFFFF;
            b = b & 256'hFFFF;
        end
        kc = (k > w) ? w : k;
        wait_idle(sel);
        @(posedge clk); #1;
        e.res = model(mode, n, a, b, kc);
        e.cyc = cyc + 1 + kc;
        if (sel) begin
            v1 = 1; md1 = mode; n1 = n[15:0]; a1 = a[15:0]; b1 = b[15:0]; k1 = 5'(k);
            q1.push_back(e);
        end else begin
            v0 = 1; md0 = mode; n0 = n; a0 = a; b0 = b; k0 = 9'(k);
            q0.push_back(e);
        end
        @(posedge clk); #1;
        v0 = 0;
        v1 = 0;
        last_cap = cyc;
    endtask

    // Full operation, also checks how long o_busy stays high.
    task automatic run_op(input bit sel, input bit mode, input logic [255:0] n,
                          input logic [255:0] a, input logic [255:0] b,
                          input int k, input string tag);
        int kc;
        int bc;
        start_op(sel, mode, n, a, b, k, kc);
        bc = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (sel ? busy1 : busy0) bc++;
            else break;
        end
        check({tag, "_busy_cycles"}, 256'(bc), 256'(kc + 1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int           kc;
        logic [255:0] n, a, b;
        int           k;
        bit           mode;

        // Reset state
        #12;
        check("reset_result", res0, 256'd0);
        check("reset_ready", 256'(rdy0), 256'd0);
        check("reset_busy", 256'(busy0), 256'd0);
        #11 rst_n = 1;

        // Basic product and pre-scale
        run_op(0, 0, 256'd18795, 256'd1000, 256'd1000, 14, "basic");
        check("basic_value", res0, 256'd3865);
        run_op(0, 1, 256'd18795, rand_bits(256), 256'd1000, 14, "prescale");
        check("prescale_value", res0, 256'd13555);

        // Abort in CALC at cycle 5: no pulse, result held
        start_op(0, 0, 256'd18795, 256'd1000, 256'd1000, 14, kc);
        void'(q0.pop_back());
        repeat (5) @(posedge clk);
        #1 ab0 = 1;
        @(posedge clk); #1 ab0 = 0;
        @(negedge clk);
        check("abort_busy", 256'(busy0), 256'd0);
        check("abort_result_held", res0, 256'd13555);
        repeat (20) @(negedge clk);
        check("abort_stays_idle", 256'(busy0), 256'd0);

        // Abort has priority over a start in IDLE
        @(posedge clk); #1;
        v0 = 1; ab0 = 1;
        @(posedge clk); #1;
        v0 = 0; ab0 = 0;
        @(negedge clk);
        check("idle_abort_no_start", 256'(busy0), 256'd0);

        // Corner values
        run_op(0, 0, 256'd18795, rand_bits(256), 256'd500, 0, "k0_mode0");
        check("k0_mode0_value", res0, 256'd0);
        run_op(0, 1, 256'd18795, rand_bits(256), 256'd7, 0, "k0_mode1");
        check("k0_mode1_value", res0, 256'd7);
        run_op(0, 0, 256'd0, 256'd12345, 256'd5, 10, "n0_mode0");
        check("n0_value", res0, 256'd0);
        run_op(0, 1, 256'd0, 256'd0, 256'd9, 3, "n0_mode1");

        // Held i_valid: one start per visit, k'+1 apart (timing checked by monitor)
        wait_idle(0);
        @(posedge clk); #1;
        v0 = 1; md0 = 0; n0 = 256'd18795; a0 = 256'd13; b0 = 256'd1000; k0 = 9'd4;
        for (int i = 0; i < 3; i++) begin
            e0.res = 256'd13000;
            e0.cyc = cyc + 1 + i * 5 + 4;
            q0.push_back(e0);
        end
        repeat (11) @(posedge clk);
        #1 v0 = 0;
        wait_idle(0);
        check("b2b_drained", 256'(q0.size()), 256'd0);

        // Small-width instance, including k clamp
        run_op(1, 0, 256'd65521, 256'd65520, 256'd65520, 16, "w16");
        check("w16_value", 256'(res1), 256'd1);
        run_op(1, 0, 256'd65521, 256'd65520, 256'd65520, 20, "w16_clamp");

        // Reset mid-operation at cycle 7
        start_op(0, 0, 256'd18795, 256'd1000, 256'd1000, 14, kc);
        void'(q0.pop_back());
        repeat (7) @(posedge clk);
        #3 rst_n = 0;
        #1;
        check("midreset_result", res0, 256'd0);
        check("midreset_ready", 256'(rdy0), 256'd0);
        check("midreset_busy", 256'(busy0), 256'd0);
        repeat (3) @(posedge clk);
        #3 rst_n = 1;
        repeat (20) @(negedge clk);
        check("postreset_idle", 256'(busy0), 256'd0);
        run_op(0, 0, 256'd18795, 256'd1000, 256'd1000, 14, "postreset");
        check("postreset_value", res0, 256'd3865);

        // Randomised operations on both widths
        for (int i = 0; i < 15; i++) begin
            n = rand_bits($urandom_range(1, 256));
            if (n == '0) n = 256'd1;
            b = rand_bits(256) % n;
            a = rand_bits(256);
            k = $urandom_range(0, 260);
            mode = 1'($urandom);
            run_op(0, mode, n, a, b, k, "rand256");
        end
        for (int i = 0; i < 15; i++) begin
            n = rand_bits($urandom_range(1, 16));
            if (n == '0) n = 256'd1;
            b = rand_bits(16) % n;
            a = rand_bits(16);
            k = $urandom_range(0, 20);
            mode = 1'($urandom);
            run_op(1, mode, n, a, b, k, "rand16");
        end

        repeat (5) @(negedge clk);
        check("sb256_drained", 256'(q0.size()), 256'd0);
        check("sb16_drained", 256'(q1.size()), 256'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
